// File: rtl/nios2_sopc_tdp_ram.sv
// nios2_sopc_tdp_ram: true-dual-port Avalon-MM RAM with power-on clear, collision rules and optional output register
module nios2_sopc_tdp_ram_rport #(
    parameter int DATA_WIDTH = 32,
    parameter int OUTPUT_REG = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rd,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] readdata,
    output logic                  readdatavalid
);
    logic [DATA_WIDTH-1:0] q;
    logic                  qv;

    // din is sampled before this edge's writes land, giving old-data reads
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            q  <= '0;
            qv <= 1'b0;
        end else begin
            qv <= rd;
            if (rd) q <= din;
        end

    if (OUTPUT_REG != 0) begin : g_reg
        always_ff @(posedge clk or posedge reset)
            if (reset) begin
                readdata      <= '0;
                readdatavalid <= 1'b0;
            end else begin
                readdatavalid <= qv;
                if (qv) readdata <= q;
            end
    end else begin : g_dir
        assign readdata      = q;
        assign readdatavalid = qv;
    end
endmodule

module nios2_sopc_tdp_ram #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 8,
    parameter int OUTPUT_REG     = 0,
    parameter int CLEAR_ON_RESET = 1,
    parameter int WRITE_PRIORITY = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    reset_req,
    output logic                    init_done,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic [DATA_WIDTH/8-1:0] byteenable,
    input  logic                    chipselect,
    input  logic                    write,
    input  logic                    clken,
    input  logic [DATA_WIDTH-1:0]   writedata,
    output logic [DATA_WIDTH-1:0]   readdata,
    output logic                    readdatavalid,
    output logic                    waitrequest,
    input  logic [ADDR_WIDTH-1:0]   address2,
    input  logic [DATA_WIDTH/8-1:0] byteenable2,
    input  logic                    chipselect2,
    input  logic                    write2,
    input  logic                    clken2,
    input  logic [DATA_WIDTH-1:0]   writedata2,
    output logic [DATA_WIDTH-1:0]   readdata2,
    output logic                    readdatavalid2,
    output logic                    waitrequest2
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int HI = (WRITE_PRIORITY != 0) ? 1 : 0;
    localparam int LO = 1 - HI;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] clr_cnt;
    logic                  clearing;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] a [2];
    logic [NB-1:0]         be [2];
    logic [DATA_WIDTH-1:0] wd [2];
    logic                  acc [2];
    logic                  wr [2];
    logic                  rd [2];

    always_ff @(posedge clk or posedge reset)
        if (reset) state <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
        else state <= state_nxt;

    always_comb state_nxt = (state == CLEAR && clr_cnt == '1) ? RUN : state;

    always_comb begin
        clearing  = state == CLEAR;
        init_done = state == RUN;
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) clr_cnt <= '0;
        else if (clearing) clr_cnt <= clr_cnt + ADDR_WIDTH'(1);

    assign waitrequest  = clearing | reset_req;
    assign waitrequest2 = clearing | reset_req;

    assign a[0]   = address;
    assign a[1]   = address2;
    assign be[0]  = byteenable;
    assign be[1]  = byteenable2;
    assign wd[0]  = writedata;
    assign wd[1]  = writedata2;
    assign acc[0] = chipselect & clken & ~waitrequest;
    assign acc[1] = chipselect2 & clken2 & ~waitrequest2;
    assign wr[0]  = acc[0] & write;
    assign wr[1]  = acc[1] & write2;
    assign rd[0]  = acc[0] & ~write;
    assign rd[1]  = acc[1] & ~write2;

    // the priority port is applied last so it overrides shared byte lanes
    always_ff @(posedge clk)
        if (clearing) mem[clr_cnt] <= '0;
        else
            for (int i = 0; i < NB; i++) begin
                if (wr[LO] && be[LO][i]) mem[a[LO]][8*i +: 8] <= wd[LO][8*i +: 8];
                if (wr[HI] && be[HI][i]) mem[a[HI]][8*i +: 8] <= wd[HI][8*i +: 8];
            end

    nios2_sopc_tdp_ram_rport #(.DATA_WIDTH(DATA_WIDTH), .OUTPUT_REG(OUTPUT_REG)) u_rport1 (
        .clk(clk), .reset(reset), .rd(rd[0]), .din(mem[a[0]]),
        .readdata(readdata), .readdatavalid(readdatavalid)
    );

    nios2_sopc_tdp_ram_rport #(.DATA_WIDTH(DATA_WIDTH), .OUTPUT_REG(OUTPUT_REG)) u_rport2 (
        .clk(clk), .reset(reset), .rd(rd[1]), .din(mem[a[1]]),
        .readdata(readdata2), .readdatavalid(readdatavalid2)
    );
endmodule

// File: tb/tb_nios2_sopc_tdp_ram.sv
// tb_nios2_sopc_tdp_ram: directed checks of a default instance and an OUTPUT_REG=1, WRITE_PRIORITY=1 instance
module tb_nios2_sopc_tdp_ram;
    logic        clk = 0, reset = 1, reset_req = 0;
    logic [7:0]  address = 0, address2 = 0;
    logic [3:0]  byteenable = 0, byteenable2 = 0;
    logic        chipselect = 0, chipselect2 = 0, write = 0, write2 = 0, clken = 1, clken2 = 1;
    logic [31:0] writedata = 0, writedata2 = 0;
    logic [31:0] d0_rd, d0_rd2, d1_rd, d1_rd2;
    logic        d0_rdv, d0_rdv2, d0_wr, d0_wr2, d0_done;
    logic        d1_rdv, d1_rdv2, d1_wr, d1_wr2, d1_done;
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    nios2_sopc_tdp_ram dut0 (
        .clk(clk), .reset(reset), .reset_req(reset_req), .init_done(d0_done),
        .address(address), .byteenable(byteenable), .chipselect(chipselect), .write(write),
        .clken(clken), .writedata(writedata), .readdata(d0_rd), .readdatavalid(d0_rdv), .waitrequest(d0_wr),
        .address2(address2), .byteenable2(byteenable2), .chipselect2(chipselect2), .write2(write2),
        .clken2(clken2), .writedata2(writedata2), .readdata2(d0_rd2), .readdatavalid2(d0_rdv2), .waitrequest2(d0_wr2)
    );

    nios2_sopc_tdp_ram #(.OUTPUT_REG(1), .WRITE_PRIORITY(1)) dut1 (
        .clk(clk), .reset(reset), .reset_req(reset_req), .init_done(d1_done),
        .address(address), .byteenable(byteenable), .chipselect(chipselect), .write(write),
        .clken(clken), .writedata(writedata), .readdata(d1_rd), .readdatavalid(d1_rdv), .waitrequest(d1_wr),
        .address2(address2), .byteenable2(byteenable2), .chipselect2(chipselect2), .write2(write2),
        .clken2(clken2), .writedata2(writedata2), .readdata2(d1_rd2), .readdatavalid2(d1_rdv2), .waitrequest2(d1_wr2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        chipselect = 0; chipselect2 = 0; write = 0; write2 = 0;
    endtask

    task automatic count_clear(input string tag);
        int n = 0;
        while (d0_wr && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_cycles"}, n, 256);
        chk({tag, "_done0"}, d0_done, 1);
        chk({tag, "_done1"}, d1_done, 1);
    endtask

    task automatic pulse_reset_sweep(input string tag);
        reset = 1;
        @(negedge clk);
        reset = 0;
        count_clear(tag);
    endtask

    task automatic wr1(input logic [7:0] ad, input logic [3:0] be, input logic [31:0] d);
        address = ad; byteenable = be; writedata = d; write = 1; chipselect = 1;
        @(negedge clk);
        idle();
    endtask

    task automatic wr2(input logic [7:0] ad, input logic [3:0] be, input logic [31:0] d);
        address2 = ad; byteenable2 = be; writedata2 = d; write2 = 1; chipselect2 = 1;
        @(negedge clk);
        idle();
    endtask

    // dut0 answers one cycle after acceptance, dut1 two cycles after
    task automatic read_chk(input string tag, input int port, input logic [7:0] ad,
                            input logic [31:0] e0, input logic [31:0] e1);
        if (port == 1) begin address = ad; write = 0; chipselect = 1; end
        else begin address2 = ad; write2 = 0; chipselect2 = 1; end
        @(negedge clk);
        idle();
        chk({tag, "_d0"}, port == 1 ? d0_rd : d0_rd2, e0);
        chk({tag, "_d0v"}, port == 1 ? d0_rdv : d0_rdv2, 1);
        chk({tag, "_d1v_early"}, port == 1 ? d1_rdv : d1_rdv2, 0);
        @(negedge clk);
        chk({tag, "_d0v_strobe"}, port == 1 ? d0_rdv : d0_rdv2, 0);
        chk({tag, "_d1"}, port == 1 ? d1_rd : d1_rd2, e1);
        chk({tag, "_d1v"}, port == 1 ? d1_rdv : d1_rdv2, 1);
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        chk("rst_wr0", d0_wr, 1);
        chk("rst_wr1", d1_wr2, 1);
        chk("rst_done", d0_done, 0);
        chk("rst_rd", d0_rd, 0);
        chk("rst_rdv", d1_rdv, 0);
        reset = 0;
        count_clear("clear1");

        wr1(8'h00, 4'hF, 32'hFFFF_FFFF);
        wr1(8'h80, 4'hF, 32'hFFFF_FFFF);
        wr1(8'hFF, 4'hF, 32'hFFFF_FFFF);
        read_chk("preload", 1, 8'h80, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        pulse_reset_sweep("clear2");
        read_chk("clr_00", 1, 8'h00, 0, 0);
        read_chk("clr_80", 2, 8'h80, 0, 0);
        read_chk("clr_ff", 1, 8'hFF, 0, 0);

        wr1(8'h10, 4'hF, 32'hAABB_CCDD);
        wr2(8'h10, 4'h5, 32'h1122_3344);
        read_chk("bytelane", 1, 8'h10, 32'hAA22_CC44, 32'hAA22_CC44);

        address = 8'h20; byteenable = 4'hF; writedata = 32'h1234_5678; write = 1; chipselect = 1;
        address2 = 8'h20; byteenable2 = 4'hC; writedata2 = 32'h9ABC_DEF0; write2 = 1; chipselect2 = 1;
        @(negedge clk);
        idle();
        read_chk("ww_coll", 2, 8'h20, 32'h1234_5678, 32'h9ABC_5678);

        address = 8'h30; write = 0; chipselect = 1;
        address2 = 8'h30; writedata2 = 32'hDEAD_BEEF; byteenable2 = 4'hF; write2 = 1; chipselect2 = 1;
        @(negedge clk);
        idle();
        chk("rw_old_d0", d0_rd, 0);
        chk("rw_old_d0v", d0_rdv, 1);
        @(negedge clk);
        chk("rw_old_d1", d1_rd, 0);
        read_chk("rw_new", 1, 8'h30, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

        for (int i = 0; i < 4; i++) wr1(8'(i), 4'hF, 32'hC0DE_0000 + i);
        for (int j = 0; j < 7; j++) begin
            if (j < 4) begin address2 = 8'(j); write2 = 0; chipselect2 = 1; end
            else idle();
            @(negedge clk);
            chk($sformatf("strm_v1_%0d", j), d1_rdv2, (j >= 1 && j <= 4) ? 1 : 0);
            if (j >= 1 && j <= 4) chk($sformatf("strm_d1_%0d", j), d1_rd2, 32'hC0DE_0000 + j - 1);
            chk($sformatf("strm_v0_%0d", j), d0_rdv2, j <= 3 ? 1 : 0);
            if (j <= 3) chk($sformatf("strm_d0_%0d", j), d0_rd2, 32'hC0DE_0000 + j);
        end

        for (int j = 0; j < 2; j++) begin
            address2 = 8'(j); write2 = 0; chipselect2 = 1;
            @(negedge clk);
        end
        idle();
        reset = 1;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk($sformatf("rstrd_v1_%0d", j), d1_rdv2, 0);
            chk($sformatf("rstrd_v0_%0d", j), d0_rdv2, 0);
        end
        reset = 0;
        count_clear("clear3");

        wr1(8'h60, 4'hF, 32'hCAFE_F00D);
        read_chk("hold_pre", 1, 8'h60, 32'hCAFE_F00D, 32'hCAFE_F00D);
        reset_req = 1;
        address = 8'h50; byteenable = 4'hF; writedata = 32'h5555_5555; write = 1; chipselect = 1;
        address2 = 8'h60; write2 = 0; chipselect2 = 1;
        for (int j = 0; j < 3; j++) begin
            #1;
            chk($sformatf("rreq_wr_%0d", j), d0_wr, 1);
            chk($sformatf("rreq_wr2_%0d", j), d1_wr2, 1);
            @(negedge clk);
            chk($sformatf("rreq_hold_%0d", j), d0_rd, 32'hCAFE_F00D);
            chk($sformatf("rreq_v2_%0d", j), d0_rdv2, 0);
            chk($sformatf("rreq_done_%0d", j), d0_done, 1);
        end
        reset_req = 0;
        idle();
        #1 chk("rreq_release", d0_wr, 0);
        read_chk("rreq_nowrite", 1, 8'h50, 0, 0);

        clken = 0;
        wr1(8'h40, 4'hF, 32'hDDDD_DDDD);
        clken = 1;
        read_chk("clken_off", 2, 8'h40, 0, 0);

        wr1(8'h70, 4'hF, 32'h7777_7777);
        reset = 1;
        @(negedge clk);
        reset = 0;
        for (int j = 0; j < 100; j++) @(negedge clk);
        chk("midclr_busy", d0_wr, 1);
        reset = 1;
        @(negedge clk);
        reset = 0;
        count_clear("clear4");
        read_chk("midclr_mem", 1, 8'h70, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
